// File: rtl/segasys1_pkg.sv
// Shared types and constants for the System 1 ROM download path.
package segasys1_pkg;

    typedef enum logic [1:0] {
        PLAIN = 2'd0,
        TYPE1 = 2'd1,
        TYPE2 = 2'd2
    } dec_type_e;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        DRAIN,
        DONE
    } romdl_state_e;

    localparam logic [24:0] DECTBL_BASE = 25'h2C100;
    localparam logic [7:0]  DEC2_MAXVAL = 8'd24;

    // Run-length step: clear on a miss, otherwise count up and stick at sat.
    function automatic logic [15:0] run_step(input logic [15:0] cnt,
                                             input logic        hit,
                                             input logic [15:0] sat);
        if (!hit)
            return '0;
        return (cnt >= sat) ? sat : cnt + 16'd1;
    endfunction

endpackage

// File: rtl/segasys1_romdl_fifo.sv
// Synchronous FIFO holding {addr, data} download entries; count/full/empty exposed.
module segasys1_romdl_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 33
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)
                rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr] <= wdata;
    end

    assign rdata = mem[rd_ptr];
    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);

endmodule

// File: rtl/segasys1_romdl.sv
// HPS ioctl download front-end: FIFO-buffered replay onto the ROM write bus
// plus decryption-table classification (enabled by SEGASYS1_ROMDL_CLASSIFY_EN).
module segasys1_romdl
    import segasys1_pkg::*;
#(
    parameter int unsigned DEPTH    = 4,
    parameter logic [24:0] TBL_BASE = DECTBL_BASE,
    parameter int unsigned RUN_LEN  = 128
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ioctl_download,
    input  logic        ioctl_wr,
    input  logic [24:0] ioctl_addr,
    input  logic [7:0]  ioctl_dout,
    output logic        ioctl_wait,
    output logic        ROMCL,
    output logic [24:0] ROMAD,
    output logic [7:0]  ROMDT,
    output logic        ROMEN,
    output logic [1:0]  dec_type,
    output logic        dl_done,
    output logic        ovf
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;

    romdl_state_e    state_q;
    romdl_state_e    state_d;
    logic            dl_q;
    logic            dl_rise;
    logic            dl_fall;
    logic            pop_stall;
    logic [CW-1:0]   fifo_count;
    logic            fifo_full;
    logic            fifo_empty;
    logic [32:0]     fifo_head;
    logic            issue_fifo;
    logic            issue_bypass;
    logic            fifo_push;

    // Replay stall hook; tied off in normal use.
    assign pop_stall = 1'b0;

    assign ROMCL   = clk;
    assign dl_rise = ioctl_download && !dl_q;
    assign dl_fall = !ioctl_download && dl_q;

    // An empty FIFO forwards the incoming byte straight to the output register,
    // giving one-cycle write-to-ROMEN latency.
    always_comb begin
        issue_fifo   = !fifo_empty && !pop_stall;
        issue_bypass = fifo_empty && ioctl_wr && !pop_stall;
        fifo_push    = ioctl_wr && !issue_bypass;
    end

    segasys1_romdl_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (33)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (fifo_push),
        .wdata ({ioctl_addr, ioctl_dout}),
        .pop   (issue_fifo),
        .rdata (fifo_head),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ROMEN <= 1'b0;
            ROMAD <= '0;
            ROMDT <= '0;
        end else begin
            ROMEN <= issue_fifo || issue_bypass;
            if (issue_fifo) begin
                {ROMAD, ROMDT} <= fifo_head;
            end else if (issue_bypass) begin
                ROMAD <= ioctl_addr;
                ROMDT <= ioctl_dout;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            dl_q       <= 1'b0;
            ovf        <= 1'b0;
            ioctl_wait <= 1'b0;
        end else begin
            state_q    <= state_d;
            dl_q       <= ioctl_download;
            ioctl_wait <= (fifo_count >= CW'(DEPTH - 1));
            if (dl_rise)
                ovf <= 1'b0;
            else if (fifo_push && fifo_full)
                ovf <= 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (dl_rise) state_d = LOAD;
            LOAD:    if (dl_fall) state_d = DRAIN;
            DRAIN:   if (fifo_empty && !ROMEN && !ioctl_wr) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (dl_rise)
            state_d = LOAD;
    end

    assign dl_done = (state_q == DONE);

`ifdef SEGASYS1_ROMDL_CLASSIFY_EN
    localparam logic [15:0] RUN_MAX = 16'(RUN_LEN);

    logic [15:0] z_run;
    logic [15:0] s_run;
    dec_type_e   dec_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            z_run <= '0;
            s_run <= '0;
            dec_q <= PLAIN;
        end else begin
            if (dl_rise) begin
                z_run <= '0;
                s_run <= '0;
            end else if (ROMEN) begin
                if (ROMAD < TBL_BASE) begin
                    z_run <= '0;
                    s_run <= '0;
                end else begin
                    z_run <= run_step(z_run, ROMDT == 8'd0, RUN_MAX);
                    s_run <= run_step(s_run, ROMDT < DEC2_MAXVAL, RUN_MAX);
                end
            end
            if (state_d == DONE && state_q != DONE)
                dec_q <= (z_run >= RUN_MAX) ? PLAIN :
                         (s_run >= RUN_MAX) ? TYPE2 : TYPE1;
        end
    end

    assign dec_type = dec_q;
`else
    assign dec_type = TYPE1;
`endif

endmodule
